communication_transmitter: RTL and testbench

//  Serialises one game message (ball hand-off, miss, presence check/reply, I-lost, new-game) into a

---
 rtl/communication_transmitter_pkg.sv | 62 ++++++
 rtl/communication_transmitter_if.sv | 24 ++
 rtl/communication_transmitter_neo_bit_encoder.sv | 53 +++++
 rtl/communication_transmitter.sv | 153 +++++++++++++++
 tb/tb_communication_transmitter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/communication_transmitter_pkg.sv
// Shared message codes, frame layout and default link timing for the board-to-board
// pulse-width link; used by both the transmitter and the receiver.
package communication_transmitter_pkg;

    typedef enum logic [2:0] {
        MSG_RSVD0         = 3'd0,
        MSG_BALL          = 3'd1,
        MSG_MISS          = 3'd2,
        MSG_ARE_YOU_THERE = 3'd3,
        MSG_I_AM_HERE     = 3'd4,
        MSG_I_LOST        = 3'd5,
        MSG_NEW_GAME      = 3'd6,
        MSG_RSVD7         = 3'd7
    } msg_t;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned TYPE_W     = 3;
    localparam int unsigned BALL_Y_W   = 9;
    localparam int unsigned VEL_W      = 4;

    localparam int unsigned TYPE_LSB   = 21;
    localparam int unsigned BALL_Y_LSB = 12;
    localparam int unsigned VEL_X_LSB  = 8;
    localparam int unsigned VEL_Y_LSB  = 4;
    localparam int unsigned SIGN_POS   = 3;
    localparam int unsigned PARITY_POS = 0;

    localparam int unsigned DEF_BIT_CYCLES = 100;
    localparam int unsigned DEF_ONE_HIGH   = 70;
    localparam int unsigned DEF_ZERO_HIGH  = 30;
    localparam int unsigned DEF_GAP_CYCLES = 500;

    typedef struct packed {
        msg_t                  msg_type;
        logic [BALL_Y_W-1:0]   ball_y;
        logic [VEL_W-1:0]      vel_x;
        logic [VEL_W-1:0]      vel_y;
        logic                  sign_y;
    } tx_msg_t;

    function automatic logic is_reserved(input logic [TYPE_W-1:0] code);
        return (code == TYPE_W'(MSG_RSVD0)) || (code == TYPE_W'(MSG_RSVD7));
    endfunction

    // Ball payload only travels with MSG_BALL; every other type sends zeros there.
    function automatic logic [FRAME_BITS-1:0] pack_frame(input tx_msg_t m, input logic parity_en);
        logic [FRAME_BITS-1:0] frame;
        frame = '0;
        frame[TYPE_LSB +: TYPE_W] = m.msg_type;
        if (m.msg_type == MSG_BALL) begin
            frame[BALL_Y_LSB +: BALL_Y_W] = m.ball_y;
            frame[VEL_X_LSB +: VEL_W]     = m.vel_x;
            frame[VEL_Y_LSB +: VEL_W]     = m.vel_y;
            frame[SIGN_POS]               = m.sign_y;
        end
        if (parity_en) begin
            frame[PARITY_POS] = ^frame[FRAME_BITS-1:PARITY_POS+1];
        end
        return frame;
    endfunction

endpackage

// File: rtl/communication_transmitter_if.sv
// Message hand-off bus between the game FSM (master) and the link transmitter (slave).
interface communication_transmitter_if;

    logic                                           tx_valid;
    logic                                           tx_ready;
    logic [communication_transmitter_pkg::TYPE_W-1:0]   msg_type;
    logic [communication_transmitter_pkg::BALL_Y_W-1:0] ball_y_tx;
    logic [communication_transmitter_pkg::VEL_W-1:0]    velocity_x_tx;
    logic [communication_transmitter_pkg::VEL_W-1:0]    velocity_y_tx;
    logic                                           sign_y_tx;
    logic                                           tx_done;
    logic                                           bad_type;

    modport master (
        output tx_valid, msg_type, ball_y_tx, velocity_x_tx, velocity_y_tx, sign_y_tx,
        input  tx_ready, tx_done, bad_type
    );

    modport slave (
        input  tx_valid, msg_type, ball_y_tx, velocity_x_tx, velocity_y_tx, sign_y_tx,
        output tx_ready, tx_done, bad_type
    );

endinterface

// File: rtl/communication_transmitter_neo_bit_encoder.sv
// Emits one pulse-width encoded bit period: high for ONE_HIGH/ZERO_HIGH clocks, low for the rest.
// A start on the last cycle of a period chains the next bit with no idle cycle.
module communication_transmitter_neo_bit_encoder #(
    parameter int unsigned BIT_CYCLES = 100,
    parameter int unsigned ONE_HIGH   = 70,
    parameter int unsigned ZERO_HIGH  = 30,
    parameter int unsigned CNT_W      = 9
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic line,
    output logic high_end_c,
    output logic bit_done_c
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_LEN  = CNT_W'(ONE_HIGH);
    localparam logic [CNT_W-1:0] ZERO_LEN = CNT_W'(ZERO_HIGH);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_len;

    assign high_end_c = active && (cnt == hi_len - CNT_W'(1));
    assign bit_done_c = active && (cnt == LAST_CNT);

    // cnt is the index of the current clock within the bit period
    always_ff @(posedge clock) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            hi_len <= '0;
            line   <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            hi_len <= bit_val ? ONE_LEN : ZERO_LEN;
            line   <= 1'b1;
        end else if (active) begin
            if (cnt == LAST_CNT) begin
                active <= 1'b0;
                cnt    <= '0;
                line   <= 1'b0;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                line <= (cnt + CNT_W'(1)) < hi_len;
            end
        end
    end

endmodule

// File: rtl/communication_transmitter.sv
// Serialises one game message into a 24-bit pulse-width frame on NEO_OUT, MSB first.
// Define COMM_TX_PARITY_EN to send even parity in bit 0 (receiver must match).
module communication_transmitter
    import communication_transmitter_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int unsigned ONE_HIGH   = DEF_ONE_HIGH,
    parameter int unsigned ZERO_HIGH  = DEF_ZERO_HIGH,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                        clock,
    input  logic                        reset,
    communication_transmitter_if.slave  bus,
    output logic                        NEO_OUT
);

    localparam int unsigned CNT_W = $clog2(((BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES) + 1);
    localparam int unsigned IDX_W = 5;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_PRE  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(FRAME_BITS - 1);

`ifdef COMM_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } state_t;

    state_t                state;
    logic [FRAME_BITS-1:0] shreg;
    logic [IDX_W-1:0]      bit_idx;
    logic [CNT_W-1:0]      gap_cnt;
    logic                  tx_ready_q;
    logic                  tx_done_q;
    logic                  bad_type_q;

    tx_msg_t               msg_c;
    logic [FRAME_BITS-1:0] frame_c;
    logic                  accept_c;
    logic                  reserved_c;
    logic                  chain_c;
    logic                  start_c;
    logic                  bit_val_c;
    logic                  high_end_c;
    logic                  bit_done_c;

    assign bus.tx_ready = tx_ready_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.bad_type = bad_type_q;

    always_comb begin
        msg_c          = '0;
        msg_c.msg_type = msg_t'(bus.msg_type);
        msg_c.ball_y   = bus.ball_y_tx;
        msg_c.vel_x    = bus.velocity_x_tx;
        msg_c.vel_y    = bus.velocity_y_tx;
        msg_c.sign_y   = bus.sign_y_tx;
    end

    assign frame_c    = pack_frame(msg_c, PARITY_EN);
    assign accept_c   = (state == ST_IDLE) && bus.tx_valid && tx_ready_q;
    assign reserved_c = is_reserved(bus.msg_type);

    // shreg is shifted at the end of each high phase, so its MSB is the next bit to send
    assign chain_c   = (state == ST_LOW) && bit_done_c && (bit_idx != '0);
    assign start_c   = (accept_c && !reserved_c) || chain_c;
    assign bit_val_c = (state == ST_IDLE) ? frame_c[FRAME_BITS-1] : shreg[FRAME_BITS-1];

    communication_transmitter_neo_bit_encoder #(
        .BIT_CYCLES (BIT_CYCLES),
        .ONE_HIGH   (ONE_HIGH),
        .ZERO_HIGH  (ZERO_HIGH),
        .CNT_W      (CNT_W)
    ) u_encoder (
        .clock      (clock),
        .reset      (reset),
        .start      (start_c),
        .bit_val    (bit_val_c),
        .line       (NEO_OUT),
        .high_end_c (high_end_c),
        .bit_done_c (bit_done_c)
    );

    // Frame sequencer; the gap state holds GAP_CYCLES+1 clocks with tx_done on the last one
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            bad_type_q <= 1'b0;
        end else begin
            tx_done_q  <= 1'b0;
            bad_type_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        tx_ready_q <= 1'b0;
                        if (reserved_c) begin
                            bad_type_q <= 1'b1;
                        end else begin
                            shreg   <= frame_c;
                            bit_idx <= IDX_TOP;
                            state   <= ST_HIGH;
                        end
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (high_end_c) begin
                        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                        state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (bit_done_c) begin
                        if (bit_idx == '0) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            bit_idx <= bit_idx - IDX_W'(1);
                            state   <= ST_HIGH;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        tx_ready_q <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                        if (gap_cnt == GAP_PRE) begin
                            tx_done_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_communication_transmitter.sv
// Self-checking bench: decodes NEO_OUT pulse widths back into frames and compares them
// against frames built arithmetically from the message fields.
module tb_communication_transmitter;

    localparam int BIT  = 100;
    localparam int ONE  = 70;
    localparam int ZERO = 30;
    localparam int GAP  = 500;

    logic clk = 1'b0;
    logic rst;
    logic neo;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    communication_transmitter_if bus();

    communication_transmitter #(
        .BIT_CYCLES (BIT),
        .ONE_HIGH   (ONE),
        .ZERO_HIGH  (ZERO),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock   (clk),
        .reset   (rst),
        .bus     (bus.slave),
        .NEO_OUT (neo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame = type | ball payload (BALL only) | optional even parity, built with plain arithmetic
    function automatic logic [23:0] model_frame(input int t, input int y, input int vx,
                                                input int vy, input int s);
        int f;
        f = t * (1 << 21);
        if (t == 1) f = f + y * (1 << 12) + vx * 256 + vy * 16 + s * 8;
`ifdef COMM_TX_PARITY_EN
        if (($countones(f) % 2) == 1) f = f + 1;
`endif
        return 24'(f);
    endfunction

    task automatic scramble();
        bus.msg_type      = 3'($urandom);
        bus.ball_y_tx     = 9'($urandom);
        bus.velocity_x_tx = 4'($urandom);
        bus.velocity_y_tx = 4'($urandom);
        bus.sign_y_tx     = 1'($urandom);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int t, input int y, input int vx, input int vy, input int s,
                        input bit hold);
        int waited;
        waited            = 0;
        bus.msg_type      = 3'(t);
        bus.ball_y_tx     = 9'(y);
        bus.velocity_x_tx = 4'(vx);
        bus.velocity_y_tx = 4'(vy);
        bus.sign_y_tx     = 1'(s);
        bus.tx_valid      = 1'b1;
        while (bus.tx_ready !== 1'b1 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (bus.tx_ready !== 1'b1) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            bus.tx_valid = 1'b0;
            scramble();
        end
    endtask

    // Starts at the negedge after accept; ends at the negedge after tx_done.
    task automatic decode(input string tag, output logic [23:0] f, output int first_h,
                          output int rise_c, output int done_c, output int fall_c);
        int h, l, bad, busy;
        bad     = 0;
        busy    = 0;
        f       = '0;
        first_h = 0;
        fall_c  = 0;
        check({tag, "_rise"}, 32'(neo), 32'd1);
        rise_c = cyc;
        for (int i = 23; i >= 0; i--) begin
            h = 0;
            while (neo === 1'b1 && h < 200) begin
                if (bus.tx_ready !== 1'b0) busy++;
                h++;
                @(negedge clk);
            end
            if (i == 23) first_h = h;
            if (h != ONE && h != ZERO) bad++;
            f[i]   = (h == ONE);
            fall_c = cyc;
            l = 0;
            while (neo === 1'b0 && bus.tx_done !== 1'b1 && l < 1000) begin
                if (bus.tx_ready !== 1'b0) busy++;
                l++;
                @(negedge clk);
            end
            if (i > 0 && h + l != BIT) bad++;
            if (i == 0 && h + l != BIT + GAP) bad++;
        end
        done_c = cyc;
        check({tag, "_widths_bad"}, 32'(bad), 32'd0);
        check({tag, "_ready_while_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_latency"}, 32'(done_c - rise_c), 32'(24 * BIT + GAP));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(bus.tx_done), 32'd0);
        check({tag, "_ready_after_done"}, 32'(bus.tx_ready), 32'd1);
    endtask

    initial begin
        logic [23:0] f, f2;
        int fh, rc, dc, fc, rc2, dc2, fc2, t, y, vx, vy, s, hits;

        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        check("rst_neo", 32'(neo), 32'd0);
        check("rst_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_done", 32'(bus.tx_done), 32'd0);
        check("rst_bad_type", 32'(bus.bad_type), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed BALL frame
        send(1, 'h1A5, 3, 5, 1, 1'b0);
        decode("t1", f, fh, rc, dc, fc);
`ifdef COMM_TX_PARITY_EN
        check("t1_frame", 32'(f), 32'h3A5359);
`else
        check("t1_frame", 32'(f), 32'h3A5358);
`endif
        check("t1_first_high", 32'(fh), 32'(ZERO));

        // MISS with a non-zero ball_y that must be suppressed
        send(2, 'h1FF, 15, 15, 1, 1'b0);
        decode("t2", f, fh, rc, dc, fc);
`ifdef COMM_TX_PARITY_EN
        check("t2_frame", 32'(f), 32'h400001);
`else
        check("t2_frame", 32'(f), 32'h400000);
`endif

        // tx_valid held across two messages
        send(3, 0, 0, 0, 0, 1'b1);
        bus.msg_type = 3'd4;
        decode("t3a", f, fh, rc, dc, fc);
        @(posedge clk);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        decode("t3b", f2, fh, rc2, dc2, fc2);
        check("t3a_frame", 32'(f), 32'(model_frame(3, 0, 0, 0, 0)));
        check("t3b_frame", 32'(f2), 32'(model_frame(4, 0, 0, 0, 0)));
        check("t3_restart", 32'(rc2 - dc), 32'd2);
        check("t3_gap_min", 32'((rc2 - fc) >= GAP), 32'd1);

        // Reserved types are dropped with a bad_type pulse
        for (int k = 0; k < 2; k++) begin
            bus.msg_type = (k == 0) ? 3'd7 : 3'd0;
            bus.tx_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.tx_valid = 1'b0;
            check("t4_bad_pulse", 32'(bus.bad_type), 32'd1);
            @(negedge clk);
            check("t4_bad_clear", 32'(bus.bad_type), 32'd0);
            check("t4_ready_back", 32'(bus.tx_ready), 32'd1);
            hits = 0;
            repeat (150) begin
                if (neo !== 1'b0) hits++;
                @(negedge clk);
            end
            check("t4_line_quiet", 32'(hits), 32'd0);
        end

        // Reset during the high phase of bit 10
        send(5, 0, 0, 0, 0, 1'b0);
        repeat (13 * BIT + 10) @(negedge clk);
        check("t5_mid_high", 32'(neo), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_line_cut", 32'(neo), 32'd0);
        check("t5_ready", 32'(bus.tx_ready), 32'd1);
        rst  = 1'b0;
        hits = 0;
        repeat (3000) begin
            if (bus.tx_done !== 1'b0 || neo !== 1'b0) hits++;
            @(negedge clk);
        end
        check("t5_no_done", 32'(hits), 32'd0);
        send(6, 0, 0, 0, 0, 1'b0);
        decode("t5", f, fh, rc, dc, fc);
        check("t5_frame", 32'(f), 32'(model_frame(6, 0, 0, 0, 0)));

        // Random valid messages against the arithmetic model
        for (int n = 0; n < 8; n++) begin
            t  = int'($urandom_range(1, 6));
            if (n < 3) t = 1;
            y  = int'($urandom_range(0, 511));
            vx = int'($urandom_range(0, 15));
            vy = int'($urandom_range(0, 15));
            s  = int'($urandom_range(0, 1));
            send(t, y, vx, vy, s, 1'b0);
            decode("rnd", f, fh, rc, dc, fc);
            check("rnd_frame", 32'(f), 32'(model_frame(t, y, vx, vy, s)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
